uart_tx_wb: RTL and testbench

UART_TX_WB -- requirements
Module: uart_tx_wb

---
 rtl/uart_tx_wb.sv | 133 +++++++++++++
 tb/tb_uart_tx_wb.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_wb.sv
// uart_tx_wb: Wishbone-programmed 8N1 UART transmitter with a TX FIFO and a TX-done interrupt.
module uart_tx_wb #(
  parameter int          FIFO_DEPTH = 8,
  parameter logic [15:0] DIV_RESET  = 16'd867
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  input  logic [3:0]  wb_sel_i,
  output logic        wb_stall_o,
  output logic        wb_ack_o,
  output logic        wb_err_o,
  output logic [31:0] wb_dat_o,
  output logic        tx_o,
  output logic        irq_o
);
  localparam int PW = $clog2(FIFO_DEPTH);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;
  state_e      state_q;
  logic [7:0]  mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_q, rd_q;
  logic [4:0]  count_q, count_d;
  logic [15:0] div_q, div_d, cnt_q;
  logic [1:0]  ctrl_q, ctrl_d;
  logic [2:0]  bit_q;
  logic [7:0]  sh_q;
  logic        tx_q, irq_q, pend_q, ack_q, err_q;
  logic [31:0] dat_q, dat_d, status;
  logic        ack_d, err_d, accept, full, empty, busy, bit_end, push, pop, unused_bits;
  logic [1:0]  adr;
  assign unused_bits = ^{wb_adr_i[31:4], wb_adr_i[1:0], wb_dat_i[31:16], wb_sel_i[3:2]};
  assign accept  = wb_cyc_i & wb_stb_i;
  assign adr     = wb_adr_i[3:2];
  assign full    = count_q == 5'(FIFO_DEPTH);
  assign empty   = count_q == '0;
  assign busy    = state_q != IDLE;
  assign bit_end = cnt_q == '0;
  assign status  = {23'b0, count_q, pend_q, busy, empty, full};
  // Full is judged on the registered count, so a same-cycle pop never frees a slot for this push.
  assign push    = accept & wb_we_i & (adr == 2'd0) & wb_sel_i[0] & ~full;
  assign pop     = ctrl_q[0] & ~empty & ((state_q == IDLE) | ((state_q == STOP) & bit_end));
  assign err_d   = accept & (wb_we_i ? ((adr == 2'd1) | ((adr == 2'd0) & wb_sel_i[0] & full)) : (adr == 2'd0));
  assign ack_d   = accept & ~err_d;
  assign dat_d   = (accept & ~wb_we_i) ? (adr == 2'd1 ? status :
                                          adr == 2'd2 ? {16'b0, div_q} :
                                          adr == 2'd3 ? {30'b0, ctrl_q} : '0) : '0;
  assign count_d = count_q + 5'(push) - 5'(pop);
  assign div_d   = (accept & wb_we_i & (adr == 2'd2)) ?
                   {wb_sel_i[1] ? wb_dat_i[15:8] : div_q[15:8], wb_sel_i[0] ? wb_dat_i[7:0] : div_q[7:0]} : div_q;
  assign ctrl_d  = (accept & wb_we_i & (adr == 2'd3) & wb_sel_i[0]) ? wb_dat_i[1:0] : ctrl_q;
  assign wb_stall_o = 1'b0;
  assign wb_ack_o   = ack_q;
  assign wb_err_o   = err_q;
  assign wb_dat_o   = dat_q;
  assign tx_o       = tx_q;
  assign irq_o      = irq_q;
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_q] <= wb_dat_i[7:0];
  end
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      dat_q   <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
      div_q   <= DIV_RESET;
      ctrl_q  <= 2'b01;
      irq_q   <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      ack_q   <= ack_d;
      err_q   <= err_d;
      dat_q   <= dat_d;
      wr_q    <= push ? wr_q + PW'(1) : wr_q;
      rd_q    <= pop ? rd_q + PW'(1) : rd_q;
      count_q <= count_d;
      div_q   <= div_d;
      ctrl_q  <= ctrl_d;
      irq_q   <= ctrl_q[1] & empty & ~busy;
      pend_q  <= empty & ~busy;
    end
  end
  // The bit counter is reloaded only at bit boundaries, so a DIV write affects the next bit.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      tx_q    <= 1'b1;
    end else begin
      case (state_q)
        IDLE: if (pop) begin
          state_q <= START;
          tx_q    <= 1'b0;
          cnt_q   <= div_q;
          sh_q    <= mem_q[rd_q];
        end
        START: if (bit_end) begin
          state_q <= DATA;
          tx_q    <= sh_q[0];
          cnt_q   <= div_q;
          bit_q   <= '0;
        end else cnt_q <= cnt_q - 16'd1;
        DATA: if (bit_end) begin
          cnt_q <= div_q;
          if (bit_q == 3'd7) begin
            state_q <= STOP;
            tx_q    <= 1'b1;
          end else begin
            bit_q <= bit_q + 3'd1;
            sh_q  <= {1'b0, sh_q[7:1]};
            tx_q  <= sh_q[1];
          end
        end else cnt_q <= cnt_q - 16'd1;
        STOP: if (bit_end) begin
          if (pop) begin
            state_q <= START;
            tx_q    <= 1'b0;
            cnt_q   <= div_q;
            sh_q    <= mem_q[rd_q];
          end else state_q <= IDLE;
        end else cnt_q <= cnt_q - 16'd1;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_wb.sv
// tb_uart_tx_wb: random and directed Wishbone traffic checked every cycle against a queue-based line model.
module tb_uart_tx_wb;
  localparam int          DEPTH = 8;
  localparam logic [15:0] DIVR  = 16'd867;
  logic clk_i = 1'b0, reset_i = 1'b0;
  logic cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [31:0] adr = '0, dat = '0;
  logic [3:0]  sel = '0;
  logic wb_stall_o, wb_ack_o, wb_err_o, tx_o, irq_o;
  logic [31:0] wb_dat_o;
  int n_chk = 0, n_fail = 0;
  always #5 clk_i = ~clk_i;
  uart_tx_wb #(.FIFO_DEPTH(DEPTH), .DIV_RESET(DIVR)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we),
    .wb_adr_i(adr), .wb_dat_i(dat), .wb_sel_i(sel), .wb_stall_o(wb_stall_o),
    .wb_ack_o(wb_ack_o), .wb_err_o(wb_err_o), .wb_dat_o(wb_dat_o), .tx_o(tx_o), .irq_o(irq_o)
  );
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask
  // Reference model: FIFO as a queue, the serial line as a queue of pending levels.
  logic [7:0]  q[$];
  logic        lvl[$];
  logic [15:0] m_div;
  logic        m_en, m_ie, m_busy, m_tx, m_ack, m_err, m_irq, m_pend;
  logic [31:0] m_dat;
  int          m_hold, cnt0;
  logic        e0, f0, b0, acc, do_push;
  logic [1:0]  a0;
  function automatic void start_frame();
    logic [7:0] b;
    b = q.pop_front();
    lvl.delete();
    for (int i = 0; i < 8; i++) lvl.push_back(b[i]);
    lvl.push_back(1'b1);
    m_tx = 1'b0;
    m_hold = int'(m_div) + 1;
    m_busy = 1'b1;
  endfunction
  always @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      q.delete(); lvl.delete();
      m_div = DIVR; m_en = 1'b1; m_ie = 1'b0; m_busy = 1'b0; m_tx = 1'b1;
      m_ack = 1'b0; m_err = 1'b0; m_dat = '0; m_irq = 1'b0; m_pend = 1'b0; m_hold = 0;
    end else begin
      cnt0 = q.size(); e0 = (cnt0 == 0); f0 = (cnt0 >= DEPTH); b0 = m_busy;
      acc = cyc & stb; a0 = adr[3:2];
      m_ack = 1'b0; m_err = 1'b0; m_dat = '0; do_push = 1'b0;
      if (acc) begin
        if (a0 == 2'd0) begin
          if (!we || (sel[0] && f0)) m_err = 1'b1;
          else begin m_ack = 1'b1; do_push = sel[0]; end
        end else if (a0 == 2'd1) begin
          if (we) m_err = 1'b1;
          else begin m_ack = 1'b1; m_dat = {23'b0, 5'(cnt0), m_pend, b0, e0, f0}; end
        end else if (a0 == 2'd2) begin
          m_ack = 1'b1; if (!we) m_dat = {16'b0, m_div};
        end else begin
          m_ack = 1'b1; if (!we) m_dat = {30'b0, m_ie, m_en};
        end
      end
      if (!m_busy) begin
        if (m_en && !e0) start_frame();
      end else begin
        m_hold--;
        if (m_hold == 0) begin
          if (lvl.size() > 0) begin m_tx = lvl.pop_front(); m_hold = int'(m_div) + 1; end
          else if (m_en && !e0) start_frame();
          else m_busy = 1'b0;
        end
      end
      m_irq = m_ie & e0 & ~b0;
      m_pend = e0 & ~b0;
      if (do_push) q.push_back(dat[7:0]);
      if (acc && we && a0 == 2'd2) begin
        if (sel[0]) m_div[7:0] = dat[7:0];
        if (sel[1]) m_div[15:8] = dat[15:8];
      end
      if (acc && we && a0 == 2'd3 && sel[0]) {m_ie, m_en} = dat[1:0];
    end
  end
  always @(negedge clk_i) begin
    if (reset_i) begin
      chk("ack", 32'(wb_ack_o), 32'(m_ack));
      chk("err", 32'(wb_err_o), 32'(m_err));
      chk("rdata", wb_dat_o, m_dat);
      chk("tx", 32'(tx_o), 32'(m_tx));
      chk("irq", 32'(irq_o), 32'(m_irq));
      chk("stall", 32'(wb_stall_o), 32'd0);
    end
  end
  logic        r_ack, r_err;
  logic [31:0] r_dat;
  logic        s[80];
  task automatic wb(input logic w, input logic [1:0] a, input logic [31:0] d, input logic [3:0] sl);
    cyc = 1'b1; stb = 1'b1; we = w; sel = sl; dat = d;
    adr = {28'($urandom), a, 2'($urandom)};
    @(negedge clk_i);
    r_ack = wb_ack_o; r_err = wb_err_o; r_dat = wb_dat_o;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask
  task automatic wait_idle(input int lim);
    int k = 0;
    while ((m_busy || q.size() != 0) && k < lim) begin @(negedge clk_i); k++; end
    chk("drain", 32'(k < lim), 32'd1);
  endtask
  task automatic wait_fall();
    int k = 0;
    while (tx_o !== 1'b0 && k < 100) begin @(negedge clk_i); k++; end
    chk("tx_fall", 32'(tx_o), 32'd0);
  endtask
  task automatic record(input int n, input bit use_irq);
    for (int i = 0; i < n; i++) begin s[i] = use_irq ? irq_o : tx_o; @(negedge clk_i); end
  endtask
  initial begin
    logic [9:0] pat;
    int zeros;
    repeat (3) @(negedge clk_i);
    chk("rst_tx", 32'(tx_o), 32'd1);
    chk("rst_ack", 32'(wb_ack_o | wb_err_o), 32'd0);
    chk("rst_dat", wb_dat_o, 32'd0);
    chk("rst_irq", 32'(irq_o), 32'd0);
    reset_i = 1'b1;
    wb(1'b0, 2'd2, '0, 4'hF);
    chk("div_reset", r_dat, 32'(DIVR));
    // 0xA5 at DIV=3
    wb(1'b1, 2'd2, 32'd3, 4'h3);
    wb(1'b1, 2'd0, 32'hA5, 4'h1);
    chk("a5_ack", 32'(r_ack), 32'd1);
    @(negedge clk_i);
    record(40, 1'b0);
    pat = 10'b1101001010;
    for (int i = 0; i < 40; i++) chk("a5_line", 32'(s[i]), 32'(pat[i/4]));
    wait_idle(100);
    // fill with enable off, then drain back-to-back at DIV=0
    wb(1'b1, 2'd3, 32'd0, 4'h1);
    wb(1'b1, 2'd2, 32'd0, 4'h3);
    for (int i = 0; i < 9; i++) begin
      wb(1'b1, 2'd0, 32'hFF, 4'h1);
      chk("fill_ack", 32'(r_ack), 32'(i < 8));
      chk("fill_err", 32'(r_err), 32'(i == 8));
    end
    wb(1'b0, 2'd1, '0, 4'hF);
    chk("status_full", r_dat, 32'h81);
    wb(1'b1, 2'd3, 32'd1, 4'h1);
    @(negedge clk_i);
    record(80, 1'b0);
    zeros = 0;
    for (int i = 0; i < 80; i++) zeros += (s[i] == 1'b0) ? 1 : 0;
    for (int k = 0; k < 8; k++) chk("b2b_start", 32'(s[10*k]), 32'd0);
    chk("b2b_zeros", 32'(zeros), 32'd8);
    wait_idle(100);
    // DIV change from 3 to 7 during data bit 0
    wb(1'b1, 2'd2, 32'd3, 4'h3);
    wb(1'b1, 2'd0, 32'h55, 4'h1);
    wait_fall();
    fork
      record(40, 1'b0);
      begin repeat (4) @(negedge clk_i); wb(1'b1, 2'd2, 32'd7, 4'h3); end
    join
    chk("div_start_end", 32'(s[3]), 32'd0);
    chk("div_bit0_first", 32'(s[4]), 32'd1);
    chk("div_bit0_last", 32'(s[7]), 32'd1);
    chk("div_bit1_first", 32'(s[8]), 32'd0);
    chk("div_bit1_last", 32'(s[15]), 32'd0);
    chk("div_bit2_first", 32'(s[16]), 32'd1);
    wait_idle(200);
    // irq after a single DIV=0 frame
    wb(1'b1, 2'd2, 32'd0, 4'h3);
    wb(1'b1, 2'd3, 32'd3, 4'h1);
    wb(1'b1, 2'd0, 32'h3C, 4'h1);
    record(14, 1'b1);
    chk("irq_mid", 32'(s[5]), 32'd0);
    chk("irq_last_busy", 32'(s[11]), 32'd0);
    chk("irq_rise", 32'(s[12]), 32'd1);
    wb(1'b0, 2'd1, '0, 4'hF);
    chk("status_irq", r_dat, 32'hA);
    // error paths with enable off
    wb(1'b1, 2'd3, 32'd0, 4'h1);
    wb(1'b1, 2'd0, 32'h11, 4'h1);
    wb(1'b0, 2'd0, '0, 4'hF);
    chk("rd_txdata_err", 32'(r_err), 32'd1);
    wb(1'b1, 2'd1, 32'hFFFF_FFFF, 4'hF);
    chk("wr_status_err", 32'(r_err), 32'd1);
    wb(1'b1, 2'd0, 32'h22, 4'hE);
    chk("nosel_ack", 32'(r_ack), 32'd1);
    wb(1'b0, 2'd1, '0, 4'hF);
    chk("status_cnt1", r_dat, 32'h10);
    wb(1'b1, 2'd3, 32'd1, 4'h1);
    wait_idle(100);
    // reset in the 4th data bit
    wb(1'b1, 2'd2, 32'd3, 4'h3);
    wb(1'b1, 2'd0, 32'hA5, 4'h1);
    wait_fall();
    repeat (17) @(negedge clk_i);
    #2 reset_i = 1'b0;
    #1 chk("abort_tx", 32'(tx_o), 32'd1);
    repeat (2) @(negedge clk_i);
    reset_i = 1'b1;
    wb(1'b0, 2'd1, '0, 4'hF);
    chk("status_after_rst", r_dat, 32'h2);
    wb(1'b0, 2'd2, '0, 4'hF);
    chk("div_after_rst", r_dat, 32'(DIVR));
    repeat (20) @(negedge clk_i);
    // random traffic
    wb(1'b1, 2'd2, 32'd1, 4'h3);
    for (int it = 0; it < 400; it++) begin
      logic [1:0] a;
      logic [31:0] d;
      repeat ($urandom_range(0, 3)) begin cyc = 1'($urandom); stb = 1'b0; @(negedge clk_i); end
      cyc = 1'b0;
      a = 2'($urandom);
      d = a == 2'd2 ? {16'($urandom), 8'h0, 8'($urandom_range(0, 2))} :
          a == 2'd3 ? {30'($urandom), 1'($urandom), 1'($urandom_range(0, 3) != 0)} : $urandom;
      wb(1'($urandom), a, d, 4'($urandom));
    end
    wb(1'b1, 2'd3, 32'd1, 4'h1);
    wait_idle(2000);
    repeat (3) @(negedge clk_i);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
